// File: rtl/aes_encrypt_iter_pkg.sv
// Shared AES definitions: FSM encoding, forward S-box, GF(2^8) helpers.
// The decrypt side is expected to add the inverse S-box alongside these.
package aes_encrypt_iter_pkg;

    localparam int AES_BLOCK = 128;

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} fsm_t;

    // Byte b of the S-box sits at bits [8*(255-b)+7 -: 8], i.e. byte 0 in the MSBs.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // n counts from 1; AES only ever needs rcon(1..10).
    function automatic logic [7:0] rcon(input int n);
        return RCON[79 - 8 * (n - 1) -: 8];
    endfunction

    function automatic logic [7:0] byte_at(input logic [127:0] v, input int idx);
        return v[127 - 8 * idx -: 8];
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_key_expansion.sv
// keyExpansion: full combinational FIPS-197 key schedule, round key r at w[r*128 +: 128].
module keyExpansion
    import aes_encrypt_iter_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic [NK*32-1:0]      key,
    output logic [0:(NR+1)*128-1] w
);
    localparam int NW = 4 * (NR + 1);

    always_comb begin
        logic [31:0] wd [NW];
        logic [31:0] t;
        w = '0;
        for (int i = 0; i < NW; i++) begin
            t = '0;
            if (i < NK) begin
                wd[i] = key[NK*32-1-32*i -: 32];
            end else begin
                t = wd[i-1];
                if (i % NK == 0)
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / NK), 24'h0};
                else if (NK > 6 && i % NK == 4)
                    t = sub_word(t);
                wd[i] = wd[i-NK] ^ t;
            end
            w[i*32 +: 32] = wd[i];
        end
    end

endmodule

// File: rtl/aes_encrypt_iter_round_forward.sv
// round_forward: one forward cipher round; MixColumns is skipped on the final round.
module round_forward
    import aes_encrypt_iter_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] out
);
    logic [127:0] sb, sr, mc;

    // Byte i is column i/4, row i%4; ShiftRows pulls row r from column (c+r)%4.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int C = i / 4;
        localparam int R = i % 4;
        logic [7:0] a0, a1, a2, a3;
        assign sb[127-8*i -: 8] = sbox(byte_at(state, i));
        assign sr[127-8*i -: 8] = byte_at(sb, 4 * ((C + R) % 4) + R);
        assign a0 = byte_at(sr, 4 * C + R);
        assign a1 = byte_at(sr, 4 * C + (R + 1) % 4);
        assign a2 = byte_at(sr, 4 * C + (R + 2) % 4);
        assign a3 = byte_at(sr, 4 * C + (R + 3) % 4);
        assign mc[127-8*i -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    end

    assign out = (last ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES forward cipher: one round per clock, valid/ready in and out.
module aes_encrypt_iter
    import aes_encrypt_iter_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLOCK-1:0] plaintext,
    input  logic [NK*32-1:0]     key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLOCK-1:0] ciphertext
);
    localparam int RW = $clog2(NR + 1);

    if (NR != NK + 6 || !(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_cfg
        $error("aes_encrypt_iter: illegal configuration NK=%0d NR=%0d", NK, NR);
    end

    fsm_t                  fsm, fsm_nxt;
    logic [RW-1:0]         round;
    logic [AES_BLOCK-1:0]  state_reg, pt_reg, rk, rnd_out;
    logic [NK*32-1:0]      key_reg;
    logic [0:(NR+1)*128-1] w;
    logic                  last;

    // Schedule runs off the latched key so the key port is free once accepted.
    keyExpansion #(.NK(NK), .NR(NR)) u_key_exp (.key(key_reg), .w(w));

    assign last = (round == RW'(NR));
    assign rk   = w[{round, 7'b0} +: 128];

    round_forward u_round (.state(state_reg), .round_key(rk), .last(last), .out(rnd_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_nxt = LOAD;
            LOAD:    fsm_nxt = ROUND;
            ROUND:   if (last) fsm_nxt = DONE;
            DONE:    if (out_ready) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (fsm == IDLE);
        out_valid = (fsm == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round      <= '0;
            state_reg  <= '0;
            key_reg    <= '0;
            pt_reg     <= '0;
            ciphertext <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    pt_reg  <= plaintext;
                    key_reg <= key;
                end
                LOAD: begin
                    state_reg <= pt_reg ^ w[0 +: 128];
                    round     <= RW'(1);
                end
                ROUND: begin
                    state_reg <= rnd_out;
                    // Result is registered once so it survives the return to IDLE.
                    if (last) ciphertext <= rnd_out;
                    else      round      <= round + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: AES-128/192/256 instances against known vectors and a byte-level model.
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   iv, ir, ov, ordy;
    logic [127:0] pt;
    logic [255:0] key256;
    logic [127:0] ct0, ct1, ct2;
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic [7:0]   sb_ref [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_encrypt_iter #(.NK(4), .NR(10)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .plaintext(pt),
        .key(key256[255:128]), .out_valid(ov[0]), .out_ready(ordy[0]), .ciphertext(ct0));
    aes_encrypt_iter #(.NK(6), .NR(12)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .plaintext(pt),
        .key(key256[255:64]), .out_valid(ov[1]), .out_ready(ordy[1]), .ciphertext(ct1));
    aes_encrypt_iter #(.NK(8), .NR(14)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .plaintext(pt),
        .key(key256), .out_valid(ov[2]), .out_ready(ordy[2]), .ciphertext(ct2));

    typedef struct {
        int           nk;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb_ref[x[31:24]], sb_ref[x[23:16]], sb_ref[x[15:8]], sb_ref[x[7:0]]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [255:0] k, input int nk);
        int          nr;
        logic [31:0] wd [60];
        logic [31:0] tmp;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc;
        logic [127:0] res;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) wd[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = wd[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            wd[i] = wd[i-nk] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8];
        for (int r = 0; r <= nr; r++) begin
            if (r > 0) begin
                for (int j = 0; j < 16; j++) s[j] = sb_ref[s[j]];
                for (int c = 0; c < 4; c++)
                    for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
                for (int c = 0; c < 4; c++)
                    for (int rw = 0; rw < 4; rw++)
                        s[4*c+rw] = (r < nr) ? gmul(8'h02, t[4*c+rw]) ^ gmul(8'h03, t[4*c+(rw+1)%4])
                                               ^ t[4*c+(rw+2)%4] ^ t[4*c+(rw+3)%4]
                                             : t[4*c+rw];
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ wd[4*r + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [127:0] ct_of(input int idx);
        case (idx)
            0:       return ct0;
            1:       return ct1;
            default: return ct2;
        endcase
    endfunction

    function automatic int nr_of(input int idx);
        return 10 + 2 * idx;
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic issue(input int idx, input logic [127:0] p, input logic [255:0] k, output int acc);
        int n;
        n = 0;
        pt = p; key256 = k; iv[idx] = 1'b1;
        while (!ir[idx] && n < 200) begin @(posedge clk); #1; n++; end
        if (!ir[idx]) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout inst %0d in_ready=0 expected 1", idx);
        end
        @(posedge clk); #1;
        acc = cyc;
        iv[idx] = 1'b0;
    endtask

    task automatic wait_out(input int idx, output int seen);
        int n;
        n = 0;
        while (!ov[idx] && n < 200) begin @(posedge clk); #1; n++; end
        if (!ov[idx]) begin
            n_vec++; n_err++;
            $display("FAIL out_timeout inst %0d out_valid=0 expected 1", idx);
        end
        seen = cyc;
    endtask

    task automatic job(input int idx, input logic [127:0] p, input logic [255:0] k,
                       input logic [127:0] exp, input string nm, output int acc);
        int seen;
        issue(idx, p, k, acc);
        wait_out(idx, seen);
        check({nm, "_ct"}, ct_of(idx), exp);
        check({nm, "_latency"}, 128'(seen - acc), 128'(nr_of(idx) + 1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t         tbl [4];
        int           acc, acc_prev, seen, idx;
        logic [127:0] exp, rp;
        logic [255:0] rk;
        logic         ok;

        rst_n = 1'b0; iv = '0; ordy = 3'b111; pt = '0; key256 = '0;
        build_sbox();

        tbl[0] = '{4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                   128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tbl[1] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                   128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        tbl[2] = '{6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                   128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        tbl[3] = '{8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

        #1;
        check("reset_out_valid", 128'(ov[0]), 128'd0);
        check("reset_ciphertext", ct0, 128'd0);
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", 128'(ir), 128'b111);

        // Known-answer vectors on all three key sizes.
        for (int v = 0; v < 4; v++)
            job((tbl[v].nk - 4) / 2, tbl[v].pt, tbl[v].key, tbl[v].ct, $sformatf("kat%0d", v), acc);

        // Backpressure: result and handshake flags frozen while out_ready is low.
        ordy[0] = 1'b0;
        issue(0, tbl[1].pt, tbl[1].key, acc);
        wait_out(0, seen);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_ciphertext", ct0, tbl[1].ct);
            check("bp_out_valid", 128'(ov[0]), 128'd1);
            check("bp_in_ready", 128'(ir[0]), 128'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 128'(ov[0]), 128'd0);
        check("bp_release_hold", ct0, tbl[1].ct);
        check("bp_release_ready", 128'(ir[0]), 128'd1);

        // Input hygiene: inputs change and in_valid pulses while busy.
        rp = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        exp = aes_ref(rp, rk, 4);
        issue(0, rp, rk, acc);
        repeat (3) @(posedge clk);
        #1;
        pt = ~rp; key256 = ~rk; iv[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 iv[0] = 1'b0;
        wait_out(0, seen);
        check("hyg_ct", ct0, exp);
        check("hyg_latency", 128'(seen - acc), 128'd11);
        rp = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        exp = aes_ref(rp, rk, 4);
        issue(0, rp, rk, acc);
        check("hyg_next_accept", 128'(acc - seen), 128'd2);
        wait_out(0, seen);
        check("hyg_next_ct", ct0, exp);

        // Asynchronous reset in the middle of a job.
        issue(0, tbl[0].pt, tbl[0].key, acc);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(ov[0]), 128'd0);
        check("rst_mid_ciphertext", ct0, 128'd0);
        check("rst_mid_in_ready", 128'(ir[0]), 128'd1);
        @(posedge clk);
        #4 rst_n = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1) ok = 1'b0;
        end
        check("rst_no_partial_output", 128'(ok), 128'd1);
        rp = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        job(0, rp, rk, aes_ref(rp, rk, 4), "rst_fresh", acc);

        // Back-to-back with out_ready high: accepts spaced NR+3 apart.
        for (int v = 0; v < 3; v++) begin
            acc_prev = acc;
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
            job(0, rp, rk, aes_ref(rp, rk, 4), "b2b", acc);
            if (v > 0) check("b2b_spacing", 128'(acc - acc_prev), 128'd13);
        end

        // Randomized jobs across all key sizes.
        for (int v = 0; v < 9; v++) begin
            idx = v % 3;
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            job(idx, rp, rk, aes_ref(rp, rk, 4 + 2 * idx), $sformatf("rand_nk%0d", 4 + 2 * idx), acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
